// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared types and sizing helpers for the polar decoder blocks
package polar_pkg;

  // log2 of the largest half-node handled by the beta combiner
  localparam int MAX_LOG_HALF = 9;

  typedef enum logic [1:0] {
    IDLE,
    COMBINE,
    DONE
  } beta_state_e;

  // Width of a level field. One code beyond the largest legal level is
  // always representable so an out-of-range request can be detected.
  function automatic int level_width(input int max_log_half);
    return $clog2(max_log_half + 2);
  endfunction

endpackage

// File: rtl/beta_chunk_xor.sv
// rtl/beta_chunk_xor.sv - P-lane slice computing lower (gr) and upper (gl^gr) chunks
// Ports:
//   gl_chunk  in  P  left partial-sum lanes
//   gr_chunk  in  P  right partial-sum lanes
//   lane_mask in  P  1 = lane lies inside the node
//   lo_chunk  out P  lower-half result lanes (masked)
//   hi_chunk  out P  upper-half result lanes (masked)
module beta_chunk_xor #(
  parameter int P = 64
) (
  input  logic [P-1:0] gl_chunk,
  input  logic [P-1:0] gr_chunk,
  input  logic [P-1:0] lane_mask,
  output logic [P-1:0] lo_chunk,
  output logic [P-1:0] hi_chunk
);

  assign lo_chunk = gr_chunk & lane_mask;
  assign hi_chunk = (gl_chunk ^ gr_chunk) & lane_mask;

endmodule

// File: rtl/beta_combiner_seq.sv
// rtl/beta_combiner_seq.sv - sequential partial-sum (beta) combiner, P lanes per cycle
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    request handshake
//   level_i, gl_i, gr_i        node level and left/right partial sums
//   out_valid_o / out_ready_i  result handshake
//   g_o, level_o               combined vector and its level
//   err_o                      one-cycle pulse when an illegal level is accepted
module beta_combiner_seq
  import polar_pkg::*;
#(
  parameter int MAX_LOG_HALF = polar_pkg::MAX_LOG_HALF,
  parameter int P            = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [level_width(MAX_LOG_HALF)-1:0]   level_i,
  input  logic [(1 << MAX_LOG_HALF)-1:0]         gl_i,
  input  logic [(1 << MAX_LOG_HALF)-1:0]         gr_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [(2 << MAX_LOG_HALF)-1:0]         g_o,
  output logic [level_width(MAX_LOG_HALF)-1:0]   level_o,
  output logic                                   err_o
);

  localparam int HMAX  = 1 << MAX_LOG_HALF;
  localparam int GW    = 2 * HMAX;
  localparam int LW    = level_width(MAX_LOG_HALF);
  localparam int LOG_P = $clog2(P);
  localparam int KW    = (MAX_LOG_HALF > LOG_P) ? (MAX_LOG_HALF - LOG_P) : 1;

  beta_state_e     state_q, state_d;
  logic [HMAX-1:0] gl_q, gr_q;
  logic [GW-1:0]   g_q, g_d, wr_mask;
  logic [LW-1:0]   level_q;
  logic [KW-1:0]   k_q, k_last;
  logic            err_q;
  logic            accept, level_bad;
  int              h_val, base;

  logic [P-1:0] gl_chunk, gr_chunk, lane_mask, lo_chunk, hi_chunk;

  assign accept    = in_valid_i && (state_q == IDLE);
  assign level_bad = int'(level_i) > MAX_LOG_HALF;

  // Node geometry for the latched request
  always_comb begin
    h_val  = int'(32'd1 << level_q);
    base   = int'(k_q) << LOG_P;
    k_last = '0;
    if (int'(level_q) > LOG_P)
      k_last = KW'((32'd1 << (int'(level_q) - LOG_P)) - 32'd1);
    lane_mask = '0;
    // Only relevant for nodes narrower than P: lanes past H stay untouched
    for (int i = 0; i < P; i++)
      lane_mask[i] = (i < h_val);
  end

  assign gl_chunk = P'(gl_q >> base);
  assign gr_chunk = P'(gr_q >> base);

  beta_chunk_xor #(
    .P (P)
  ) u_chunk_xor (
    .gl_chunk  (gl_chunk),
    .gr_chunk  (gr_chunk),
    .lane_mask (lane_mask),
    .lo_chunk  (lo_chunk),
    .hi_chunk  (hi_chunk)
  );

  // Merge chunk k into the result: lower half at k*P, upper half at H + k*P
  always_comb begin
    wr_mask = (GW'(lane_mask) << base) | (GW'(lane_mask) << (base + h_val));
    g_d     = (g_q & ~wr_mask)
            | (GW'(lo_chunk) << base)
            | (GW'(hi_chunk) << (base + h_val));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i && !level_bad) state_d = COMBINE;
      COMBINE: if (k_q == k_last)           state_d = DONE;
      DONE:    if (out_ready_i)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand, result and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gl_q    <= '0;
      gr_q    <= '0;
      g_q     <= '0;
      level_q <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && level_bad;
      // An illegal request leaves the previous result untouched
      if (accept && !level_bad) begin
        gl_q    <= gl_i;
        gr_q    <= gr_i;
        level_q <= level_i;
        g_q     <= '0;
        k_q     <= '0;
      end else if (state_q == COMBINE) begin
        g_q <= g_d;
        k_q <= k_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    g_o         = g_q;
    level_o     = level_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_beta_combiner_seq.sv
// tb/tb_beta_combiner_seq.sv - directed self-checking bench for beta_combiner_seq
module tb_beta_combiner_seq;

  localparam int MLH = 3;
  localparam int P   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  level_i = '0;
  logic [7:0]  gl_i = '0;
  logic [7:0]  gr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] g_o;
  logic [2:0]  level_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  beta_combiner_seq #(
    .MAX_LOG_HALF (MLH),
    .P            (P)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .level_i     (level_i),
    .gl_i        (gl_i),
    .gr_i        (gr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .g_o         (g_o),
    .level_o     (level_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  level;
    logic [7:0]  gl;
    logic [7:0]  gr;
    int          stall;
    logic [15:0] exp_g;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int n;
    int lat;
    @(negedge clk_i);
    level_i    = v.level;
    gl_i       = v.gl;
    gr_i       = v.gr;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_accept_wait"}, 32'(n < 20), 32'd1);
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end while (!out_valid_o && lat < 50);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_g"}, 32'(g_o), 32'(v.exp_g));
    check({tag, "_level"}, 32'(level_o), 32'(v.level));
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk_i);
      check({tag, "_stall_valid"}, 32'(out_valid_o), 32'd1);
      check({tag, "_stall_g"}, 32'(g_o), 32'(v.exp_g));
      check({tag, "_stall_ready"}, 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_post_ready"}, 32'(in_ready_o), 32'd1);
    check({tag, "_post_valid"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h01, 8'h00, 0, 16'h0002, 1};
    vecs[1] = '{3'd2, 8'h0A, 8'h06, 0, 16'h00C6, 2};
    vecs[2] = '{3'd3, 8'hFF, 8'h0F, 5, 16'hF00F, 4};
    vecs[3] = '{3'd1, 8'hFE, 8'h01, 0, 16'h000D, 1};
    vecs[4] = '{3'd3, 8'hA5, 8'h3C, 2, 16'h993C, 4};
    vecs[5] = '{3'd2, 8'hFF, 8'hA5, 0, 16'h00A5, 2};
    vecs[6] = '{3'd0, 8'h00, 8'h01, 1, 16'h0003, 1};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_g", 32'(g_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);

    // Table-driven requests
    for (int i = 0; i < 7; i++)
      run_req(vecs[i], $sformatf("vec%0d", i));

    // Illegal level: single err pulse, no output, stays ready
    @(negedge clk_i);
    level_i    = 3'd4;
    gl_i       = 8'hFF;
    gr_i       = 8'hFF;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    check("illegal_err_pulse", 32'(err_o), 32'd1);
    check("illegal_in_ready", 32'(in_ready_o), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check("illegal_err_low", 32'(err_o), 32'd0);
      check("illegal_no_valid", 32'(out_valid_o), 32'd0);
      check("illegal_ready_held", 32'(in_ready_o), 32'd1);
    end

    // Reset during the second COMBINE cycle of a level-3 request
    @(negedge clk_i);
    level_i    = 3'd3;
    gl_i       = 8'hFF;
    gr_i       = 8'h0F;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("midop_partial_g", 32'(g_o), 32'h0003);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_g", 32'(g_o), 32'd0);
    check("midrst_level", 32'(level_o), 32'd0);
    run_req('{3'd1, 8'h02, 8'h01, 0, 16'h000D, 1}, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
